inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/cpu_pkg.sv | 15 +
 rtl/inst_fetch.sv | 63 ++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, opcodes and fetch-stage state encoding
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [3:0]      OPC_JMP  = 4'hB;
    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with one-word output register and redirect
// Optional build macro PREDECODE_JMP_EN: follow JMP targets at fetch time.
module inst_fetch
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            slot_free;

    assign imem_addr = pc;
    assign slot_free = !instr_valid || instr_ready;

    always_comb begin
        next_pc = pc + 8'd1;
`ifdef PREDECODE_JMP_EN
        // Target sits in the low byte of the JMP word; skip the fall-through fetch.
        if (imem_data[15:12] == OPC_JMP) begin
            next_pc = imem_data[PC_W-1:0];
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state <= fetch_en ? RUN : IDLE;

            // Redirect flushes the held word; a coincident handshake still counts as done.
            if (redirect_valid) begin
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
            end else if (state == RUN && slot_free) begin
                instr       <= imem_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= next_pc;
            end else if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
